reversible_serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder built on a reversible full-adder slice. Operands are

---
 rtl/rsa_pkg.sv | 32 +++
 rtl/rsa_bit_slice.sv | 22 ++
 rtl/reversible_serial_adder.sv | 149 ++++++++++++++
 tb/tb_reversible_serial_adder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and slice equations for the reversible serial adder.
// The optional GARB_PARITY_EN feature is handled in the top level.
package rsa_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } rsa_state_t;

  typedef struct packed {
    logic sum;
    logic cout;
    logic g0;
    logic g1;
  } rsa_slice_t;

  // Reversible full adder: g0/g1 keep enough information to undo the addition.
  function automatic rsa_slice_t rsa_slice_eval(input logic a, input logic b, input logic c);
    rsa_slice_t r;
    r.sum  = a ^ b ^ c;
    r.cout = (a & b) | (c & (a ^ b));
    r.g0   = a;
    r.g1   = a ^ b;
    return r;
  endfunction

endpackage

// File: rtl/rsa_bit_slice.sv
// Combinational reversible full-adder slice: a, b, c -> sum, cout, g0, g1.
module rsa_bit_slice
  import rsa_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout,
  output logic g0,
  output logic g1
);

  rsa_slice_t w_res;

  assign w_res = rsa_slice_eval(a, b, c);
  assign sum   = w_res.sum;
  assign cout  = w_res.cout;
  assign g0    = w_res.g0;
  assign g1    = w_res.g1;

endmodule

// File: rtl/reversible_serial_adder.sv
// Bit-serial WIDTH-bit adder driving one reversible slice, LSB first.
// Define GARB_PARITY_EN to add the garb_par output (parity of all slice g1 outputs).
module reversible_serial_adder
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef GARB_PARITY_EN
  ,
  output logic             garb_par
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  rsa_state_t       r_state;
  rsa_state_t       w_next_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_sum_b;
  logic             w_cout_b;
  logic             w_g0;
  logic             w_g1;
  logic             w_last;

  rsa_bit_slice u_slice (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .c    (r_carry),
    .sum  (w_sum_b),
    .cout (w_cout_b),
    .g0   (w_g0),
    .g1   (w_g1)
  );

  assign w_last = (r_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: start is honoured only in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = RUN;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: operand shifters, carry feedback, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (w_next_state != IDLE);
      done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
          end
        end
        RUN: begin
          sum     <= {w_sum_b, sum[WIDTH-1:1]};
          r_carry <= w_cout_b;
          r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
          // The counter parks at its last value; the final carry lands in cout.
          if (w_last) begin
            cout <= w_cout_b;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef GARB_PARITY_EN
  logic r_garb_par;
  logic w_unused_g0;

  assign w_unused_g0 = w_g0;
  assign garb_par    = r_garb_par;

  // Garbage parity accumulator over every g1 the slice produces in a run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_garb_par <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_garb_par <= 1'b0;
    end else if (r_state == RUN) begin
      r_garb_par <= r_garb_par ^ w_g1;
    end
  end
`else
  logic w_unused_garb;

  assign w_unused_garb = w_g0 ^ w_g1;
`endif

endmodule

// File: tb/tb_reversible_serial_adder.sv
// Directed self-checking bench for reversible_serial_adder (WIDTH=8).
module tb_reversible_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef GARB_PARITY_EN
  logic       garb_par;
`endif

  int checks   = 0;
  int failures = 0;

  reversible_serial_adder #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout)
`ifdef GARB_PARITY_EN
    ,
    .garb_par (garb_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; observes 14 negedges. Optionally pulses start with new
  // operands at observation points 3 and 8, which must be ignored.
  task automatic run_op(input logic [7:0] opa, input logic [7:0] opb, input logic opc,
                        input bit inject, output int lat, output int bcnt, output int dcnt);
    lat  = 0;
    bcnt = 0;
    dcnt = 0;
    a     = opa;
    b     = opb;
    cin   = opc;
    start = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat == 0) lat = i - 1;
      end
      if (inject && (i == 3 || i == 8)) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
      end else if (inject && (i == 4 || i == 9)) begin
        start = 1'b0;
      end
    end
  endtask

  int         lat;
  int         bcnt;
  int         dcnt;
  int         gap;
  logic [7:0] ra;
  logic [7:0] rb;
  logic       rc;
  logic [8:0] exp9;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum",  sum,  0);
    chk("rst_cout", cout, 0);
`ifdef GARB_PARITY_EN
    chk("rst_garb", garb_par, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // 5A + 3C
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, lat, bcnt, dcnt);
    chk("t1_latency", lat, 9);
    chk("t1_busy_cycles", bcnt, 9);
    chk("t1_done_pulses", dcnt, 1);
    chk("t1_sum", sum, 32'h96);
    chk("t1_cout", cout, 0);
`ifdef GARB_PARITY_EN
    chk("t1_garb", garb_par, 0);
`endif

    // FF + 01 wraps to 00 with carry out
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, bcnt, dcnt);
    chk("t2_latency", lat, 9);
    chk("t2_busy_cycles", bcnt, 9);
    chk("t2_sum", sum, 32'h00);
    chk("t2_cout", cout, 1);
`ifdef GARB_PARITY_EN
    chk("t2_garb", garb_par, 1);
`endif

    // FF + FF + 1, then result held while idle
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, lat, bcnt, dcnt);
    chk("t3_sum", sum, 32'hFF);
    chk("t3_cout", cout, 1);
    repeat (5) @(negedge clk);
    chk("t3_hold_sum", sum, 32'hFF);
    chk("t3_hold_cout", cout, 1);
    chk("t3_hold_busy", busy, 0);

    // start pulses mid-run with other operands are ignored
    run_op(8'h12, 8'h34, 1'b0, 1'b1, lat, bcnt, dcnt);
    chk("t4_done_pulses", dcnt, 1);
    chk("t4_latency", lat, 9);
    chk("t4_busy_cycles", bcnt, 9);
    chk("t4_sum", sum, 32'h46);
    chk("t4_cout", cout, 0);

    // reset in the middle of a run
    a     = 8'hAA;
    b     = 8'h55;
    cin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_sum", sum, 0);
    chk("t5_rst_cout", cout, 0);
    chk("t5_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, lat, bcnt, dcnt);
    chk("t5_sum", sum, 32'h02);
    chk("t5_cout", cout, 0);
    chk("t5_latency", lat, 9);

    // back-to-back random additions with start held high
    ra    = 8'($urandom);
    rb    = 8'($urandom);
    rc    = 1'($urandom);
    a     = ra;
    b     = rb;
    cin   = rc;
    start = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!done && gap < 20);
      chk("rnd_gap", gap, 10);
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      chk("rnd_result", {cout, sum}, exp9);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rc  = 1'($urandom);
      a   = ra;
      b   = rb;
      cin = rc;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
